// File: rtl/csr_counter_bank.sv
// Machine counter/event CSR bank: mcycle, minstret, mhpmcounter3.., mhpmevent3.., mcountinhibit.
// Define HPM_OVERFLOW_IRQ_EN to add sticky mhpmevent OF bits and the overflow_irq output.
module csr_counter_bank #(
  parameter int NUM_HPM       = 4,
  parameter int NUM_EVENTS    = 8,
  parameter int COUNTER_WIDTH = 64
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [11:0]           address,
  input  logic                  write_enable,
  input  logic [31:0]           write_value,
  output logic [31:0]           read_value,
  output logic                  hit,
  input  logic                  retire,
  input  logic [NUM_EVENTS-1:0] events,
  output logic                  overflow_irq
);

  localparam int W  = COUNTER_WIDTH;
  localparam int HN = (NUM_HPM > 0) ? NUM_HPM : 1;
  localparam logic [W-1:0] ONE = W'(1);
  localparam logic [31:0] INH_MASK = 32'(((64'd1 << NUM_HPM) - 64'd1) << 3) | 32'h5;

  logic [W-1:0]  mcycle;
  logic [W-1:0]  minstret;
  logic [W-1:0]  hpm_cnt [HN];
  logic [4:0]    hpm_sel [HN];
  logic [HN-1:0] hpm_of;
  logic [HN-1:0] hpm_inc;
  logic [31:0]   inhibit;
  logic [31:0]   ev_ext;
  logic [31:0]   wr_lo, wr_hi, wr_evt;
  logic          wr_inh;
  logic          is_cnt, is_cfg, we;
  logic [4:0]    idx;
  logic [W-1:0]  cnt_sel;

  // Write to either half has priority over the increment of that counter.
  function automatic logic [W-1:0] next_count(input logic [W-1:0] cur, input logic ld_lo,
                                              input logic ld_hi, input logic inc,
                                              input logic [31:0] wv);
    logic [W-1:0] n;
    n = cur;
    if (ld_lo)      n[31:0]   = wv;
    else if (ld_hi) n[W-1:32] = wv[W-33:0];
    else if (inc)   n         = cur + ONE;
    return n;
  endfunction

  assign idx    = address[4:0];
  assign is_cnt = (address[11:8] == 4'hB) && (address[6:5] == 2'b00);
  assign is_cfg = (address[11:5] == 7'b0011001);
  assign hit    = (is_cnt && idx != 5'd1) || (is_cfg && idx != 5'd1 && idx != 5'd2);
  assign we     = write_enable && hit;
  // Bit 0 is a dead slot so a selector of 0 (or beyond NUM_EVENTS) never matches.
  assign ev_ext = 32'({events, 1'b0});

  always_comb begin
    wr_lo  = '0;
    wr_hi  = '0;
    wr_evt = '0;
    wr_inh = 1'b0;
    if (we && is_cnt) begin
      if (address[7]) wr_hi[idx] = 1'b1;
      else            wr_lo[idx] = 1'b1;
    end
    if (we && is_cfg) begin
      if (idx == 5'd0) wr_inh      = 1'b1;
      else             wr_evt[idx] = 1'b1;
    end
  end

  always_comb begin
    hpm_inc = '0;
    for (int j = 0; j < HN; j++)
      if (j < NUM_HPM) hpm_inc[j] = ev_ext[hpm_sel[j]] && !inhibit[j+3];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mcycle   <= '0;
      minstret <= '0;
      inhibit  <= '0;
      for (int j = 0; j < HN; j++) begin
        hpm_cnt[j] <= '0;
        hpm_sel[j] <= '0;
      end
    end else begin
      mcycle   <= next_count(mcycle, wr_lo[0], wr_hi[0], !inhibit[0], write_value);
      minstret <= next_count(minstret, wr_lo[2], wr_hi[2], retire && !inhibit[2], write_value);
      if (wr_inh) inhibit <= write_value & INH_MASK;
      for (int j = 0; j < HN; j++) begin
        if (j < NUM_HPM) begin
          hpm_cnt[j] <= next_count(hpm_cnt[j], wr_lo[j+3], wr_hi[j+3], hpm_inc[j], write_value);
          if (wr_evt[j+3]) hpm_sel[j] <= write_value[4:0];
        end
      end
    end
  end

`ifdef HPM_OVERFLOW_IRQ_EN
  logic [HN-1:0] hpm_wrap;

  always_comb begin
    hpm_wrap = '0;
    for (int j = 0; j < HN; j++)
      if (j < NUM_HPM)
        hpm_wrap[j] = hpm_inc[j] && !wr_lo[j+3] && !wr_hi[j+3] && (&hpm_cnt[j]);
  end

  // A wrap beats a same-cycle CSR write of OF; the irq follows the OF bits one cycle late.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hpm_of       <= '0;
      overflow_irq <= 1'b0;
    end else begin
      for (int j = 0; j < HN; j++) begin
        if (hpm_wrap[j])       hpm_of[j] <= 1'b1;
        else if (wr_evt[j+3])  hpm_of[j] <= write_value[31];
      end
      overflow_irq <= |hpm_of;
    end
  end
`else
  assign hpm_of       = '0;
  assign overflow_irq = 1'b0;
`endif

  always_comb begin
    read_value = '0;
    cnt_sel    = '0;
    if (is_cnt) begin
      if (idx == 5'd0)      cnt_sel = mcycle;
      else if (idx == 5'd2) cnt_sel = minstret;
      for (int j = 0; j < HN; j++)
        if (j < NUM_HPM && idx == 5'(j + 3)) cnt_sel = hpm_cnt[j];
      read_value = address[7] ? 32'(cnt_sel[W-1:32]) : cnt_sel[31:0];
    end else if (is_cfg) begin
      if (idx == 5'd0) read_value = inhibit;
      for (int j = 0; j < HN; j++)
        if (j < NUM_HPM && idx == 5'(j + 3)) read_value = {hpm_of[j], 26'd0, hpm_sel[j]};
    end
  end

endmodule

// File: tb/tb_csr_counter_bank.sv
// Scoreboard bench for csr_counter_bank: stimulus queues expected reads, a negedge monitor checks them.
module tb_csr_counter_bank;
  localparam int NUM_HPM = 4;
  localparam int NUM_EVENTS = 8;
  localparam int CW = 40;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [11:0] address;
  logic        write_enable;
  logic [31:0] write_value;
  logic [31:0] read_value;
  logic        hit;
  logic        retire;
  logic [NUM_EVENTS-1:0] events;
  logic        overflow_irq;

  csr_counter_bank #(.NUM_HPM(NUM_HPM), .NUM_EVENTS(NUM_EVENTS), .COUNTER_WIDTH(CW)) dut (
    .clock(clock), .reset_n(reset_n), .address(address), .write_enable(write_enable),
    .write_value(write_value), .read_value(read_value), .hit(hit), .retire(retire),
    .events(events), .overflow_irq(overflow_irq)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic        irq_chk;
    logic [31:0] val;
    logic        hit;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  logic  rd_req = 1'b0;
  int    n_checks = 0;
  int    n_pass = 0;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input logic [11:0] a, input logic [31:0] v, input logic h, input string nm);
    exp_t e;
    e.irq_chk = 1'b0;
    e.val = v;
    e.hit = h;
    address = a;
    exp_q.push_back(e);
    name_q.push_back(nm);
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
  endtask

  task automatic check_irq(input logic v, input string nm);
    exp_t e;
    e.irq_chk = 1'b1;
    e.val = {31'd0, v};
    e.hit = 1'b0;
    exp_q.push_back(e);
    name_q.push_back(nm);
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] v);
    address = a;
    write_value = v;
    write_enable = 1'b1;
    tick();
    write_enable = 1'b0;
  endtask

  always @(negedge clock) begin
    exp_t  e;
    string nm;
    if (rd_req) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL monitor_underflow: no expected entry queued");
      end else begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        if (e.irq_chk) begin
          if (overflow_irq === e.val[0]) n_pass++;
          else $display("FAIL %s: overflow_irq=%0b required %0b", nm, overflow_irq, e.val[0]);
        end else begin
          if (read_value === e.val && hit === e.hit) n_pass++;
          else $display("FAIL %s: read_value=%h hit=%0b required read_value=%h hit=%0b",
                        nm, read_value, hit, e.val, e.hit);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    address = 12'h000;
    write_enable = 1'b0;
    write_value = '0;
    retire = 1'b0;
    events = '0;
    repeat (2) tick();
    check(12'hB00, 32'd0, 1'b1, "rst_mcycle");
    check(12'h320, 32'd0, 1'b1, "rst_inhibit");
    check_irq(1'b0, "rst_irq");

    // Counting starts on the first edge after release.
    reset_n = 1'b1;
    repeat (10) tick();
    check(12'hB00, 32'd10, 1'b1, "mcycle_10");
    check(12'hB80, 32'd0, 1'b1, "mcycleh_0");
    wr(12'h320, 32'h5);
    check(12'h320, 32'h5, 1'b1, "inhibit_cy_ir");
    check(12'hB00, 32'd13, 1'b1, "mcycle_held");

    // Carry across halves.
    wr(12'h320, 32'h4);
    wr(12'hB80, 32'h0);
    wr(12'hB00, 32'hFFFF_FFFE);
    repeat (2) tick();
    check(12'hB00, 32'h0, 1'b1, "carry_lo");
    check(12'hB80, 32'h1, 1'b1, "carry_hi");
    wr(12'h320, 32'h5);
    check(12'hB00, 32'd3, 1'b1, "mcycle_after_carry");

    // minstret: write beats a same-cycle retire.
    wr(12'h320, 32'h1);
    address = 12'hB02;
    write_value = 32'd7;
    write_enable = 1'b1;
    retire = 1'b1;
    tick();
    write_enable = 1'b0;
    retire = 1'b0;
    check(12'hB02, 32'd7, 1'b1, "minstret_wr_wins");
    retire = 1'b1;
    repeat (3) tick();
    retire = 1'b0;
    check(12'hB02, 32'd10, 1'b1, "minstret_retire3");
    wr(12'hB82, 32'hFFFF_FFFF);
    check(12'hB82, 32'h0000_00FF, 1'b1, "minstreth_trunc");
    check(12'hB02, 32'd10, 1'b1, "minstret_lo_hold");

    // hpm3 on event 2, then inhibited.
    wr(12'h323, 32'd2);
    for (int i = 0; i < 5; i++) begin
      events = 8'h02;
      tick();
      if (i < 3) begin
        events = 8'h01;
        tick();
      end
      events = 8'h00;
    end
    wr(12'h320, 32'h9);
    for (int i = 0; i < 4; i++) begin
      events = 8'h02;
      tick();
    end
    events = 8'h00;
    check(12'hB03, 32'd5, 1'b1, "hpm3_count");
    check(12'h323, 32'd2, 1'b1, "evt3_sel");
    wr(12'h323, 32'h7FFF_FFE2);
    check(12'h323, 32'd2, 1'b1, "evt3_mask");

    // Selector boundaries.
    wr(12'h324, 32'd9);
    events = 8'hFF;
    repeat (3) tick();
    events = 8'h00;
    check(12'hB04, 32'd0, 1'b1, "sel_gt_num");
    check(12'hB05, 32'd0, 1'b1, "sel_zero");
    wr(12'h324, 32'd8);
    events = 8'h80;
    repeat (2) tick();
    events = 8'h00;
    check(12'hB04, 32'd2, 1'b1, "sel_max");
    wr(12'h320, 32'hFFFF_FFFF);
    check(12'h320, 32'h7D, 1'b1, "inhibit_mask");

    // Ownership and unimplemented indices.
    check(12'hB10, 32'd0, 1'b1, "hpm16_unimpl");
    wr(12'hB10, 32'h1234);
    check(12'hB10, 32'd0, 1'b1, "hpm16_wr_ignored");
    check(12'h7C0, 32'd0, 1'b0, "nohit_7c0");
    check(12'hB01, 32'd0, 1'b0, "nohit_time");
    check(12'h321, 32'd0, 1'b0, "nohit_321");
    check(12'h33F, 32'd0, 1'b1, "evt31_unimpl");
    check(12'hB87, 32'd0, 1'b1, "hpm7h_unimpl");

    // Wrap of counter3 at 2^40-1.
    wr(12'h320, 32'h75);
    wr(12'hB83, 32'hFF);
    wr(12'hB03, 32'hFFFF_FFFF);
    wr(12'h323, 32'd1);
    events = 8'h01;
    tick();
    events = 8'h00;
    check(12'hB03, 32'd0, 1'b1, "wrap_lo");
    check(12'hB83, 32'd0, 1'b1, "wrap_hi");
`ifdef HPM_OVERFLOW_IRQ_EN
    check_irq(1'b1, "irq_set");
    check(12'h323, 32'h8000_0001, 1'b1, "of_set");
    wr(12'h323, 32'd1);
    check_irq(1'b1, "irq_lag");
    check_irq(1'b0, "irq_clr");
    check(12'h323, 32'd1, 1'b1, "of_clr");
`else
    check(12'h323, 32'd1, 1'b1, "of_absent");
    check_irq(1'b0, "irq_tied");
    wr(12'h323, 32'h8000_0001);
    check(12'h323, 32'd1, 1'b1, "of_wr_ignored");
`endif

    // Asynchronous reset mid-run.
    wr(12'h320, 32'h0);
    events = 8'h01;
    repeat (3) tick();
    #2 reset_n = 1'b0;
    check(12'hB00, 32'd0, 1'b1, "async_rst_mcycle");
    check(12'hB02, 32'd0, 1'b1, "async_rst_minstret");
    check(12'hB03, 32'd0, 1'b1, "async_rst_hpm3");
    check(12'h320, 32'd0, 1'b1, "async_rst_inhibit");
    check(12'h323, 32'd0, 1'b1, "async_rst_evt3");
    check_irq(1'b0, "async_rst_irq");
    events = 8'h00;
    reset_n = 1'b1;
    tick();
    check(12'hB00, 32'd1, 1'b1, "resume_after_rst");

    tick();
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
